// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: shared response codes, FSM encodings and widths for the AXI SRAM slave
package axi_sram_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         BEAT_W      = 4;
    typedef enum logic [2:0] {R_IDLE = 3'b001, R_WAIT = 3'b010, R_DATA = 3'b100} rd_state_t;
    typedef enum logic [2:0] {W_IDLE = 3'b001, W_DATA = 3'b010, W_RESP = 3'b100} wr_state_t;
endpackage

// File: rtl/axi_sram_mem.sv
// axi_sram_mem: word SRAM with registered read port, byte-enabled write port, read-first
module axi_sram_mem
    import axi_sram_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb
);
    logic [31:0] r_mem [2**AW];
    logic [31:0] r_q;
    assign o_rdata = r_q;
    // byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (i_we && i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    // output register samples the pre-write word, giving read-first on collision
    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else if (i_re) r_q <= r_mem[i_raddr];
    end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave terminating INCR bursts into a word-organised SRAM
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int MEM_AW   = 14,
    parameter int RD_DELAY = 0
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    rd_state_t          r_rstate, w_rnext;
    wr_state_t          r_wstate, w_wnext;
    logic [3:0]         r_rid, r_bid;
    logic [MEM_AW-1:0]  r_ridx, r_widx;
    logic [BEAT_W-1:0]  r_rlen, r_rbeat, r_wlen, r_wbeat;
    logic [3:0]         r_dcnt;
    logic               r_err;
    logic               w_rd_en, w_dly_done, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_wend;
    logic               w_unused;

    assign w_unused = ^{arsize, arburst, arlock, arcache, arprot, arlen[7:4], araddr[31:MEM_AW+2], araddr[1:0],
                        awsize, awburst, awlock, awcache, awprot, awlen[7:4], awaddr[31:MEM_AW+2], awaddr[1:0], wid};

    assign arready    = (r_rstate == R_IDLE) && !reset;
    assign rvalid     = r_rstate == R_DATA;
    assign rlast      = rvalid && (r_rbeat == r_rlen);
    assign rid        = r_rid;
    assign rresp      = RESP_OKAY;
    assign w_ar_hs    = arvalid && arready;
    assign w_r_hs     = rvalid && rready;
    assign w_dly_done = r_dcnt == 4'(RD_DELAY);

    assign awready = (r_wstate == W_IDLE) && !reset;
    assign wready  = r_wstate == W_DATA;
    assign bvalid  = r_wstate == W_RESP;
    assign bid     = r_bid;
    assign bresp   = (bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign w_aw_hs = awvalid && awready;
    assign w_w_hs  = wvalid && wready;
    assign w_wend  = r_wbeat == r_wlen;

    axi_sram_mem #(.AW(MEM_AW)) u_mem (
        .clk     (aclk),
        .rst     (reset),
        .i_re    (w_rd_en),
        .i_raddr (r_ridx),
        .o_rdata (rdata),
        .i_we    (w_w_hs),
        .i_waddr (r_widx),
        .i_wdata (wdata),
        .i_wstrb (wstrb)
    );

    // read FSM next state; SRAM read issued on the last wait cycle
    always_comb begin
        w_rnext = r_rstate;
        w_rd_en = 1'b0;
        unique case (r_rstate)
            R_IDLE: w_rnext = arvalid ? R_WAIT : R_IDLE;
            R_WAIT: begin
                w_rd_en = w_dly_done;
                w_rnext = w_dly_done ? R_DATA : R_WAIT;
            end
            R_DATA: w_rnext = !rready ? R_DATA : (rlast ? R_IDLE : R_WAIT);
            default: w_rnext = R_IDLE;
        endcase
    end

    // read state register and burst bookkeeping
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rbeat  <= '0;
            r_dcnt   <= '0;
        end else begin
            r_rstate <= w_rnext;
            if (w_ar_hs) begin
                r_rid   <= arid;
                r_ridx  <= araddr[MEM_AW+1:2];
                r_rlen  <= arlen[3:0];
                r_rbeat <= '0;
                r_dcnt  <= '0;
            end
            if (r_rstate == R_WAIT) r_dcnt <= w_dly_done ? 4'd0 : r_dcnt + 4'd1;
            if (w_r_hs && !rlast) begin
                r_ridx  <= r_ridx + MEM_AW'(1);
                r_rbeat <= r_rbeat + BEAT_W'(1);
            end
        end
    end

    // write FSM next state; burst ends on the beat count, not on wlast
    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            W_IDLE:  w_wnext = awvalid ? W_DATA : W_IDLE;
            W_DATA:  w_wnext = (wvalid && w_wend) ? W_RESP : W_DATA;
            W_RESP:  w_wnext = bready ? W_IDLE : W_RESP;
            default: w_wnext = W_IDLE;
        endcase
    end

    // write state register, index advance and wlast mismatch tracking
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_bid    <= '0;
            r_widx   <= '0;
            r_wlen   <= '0;
            r_wbeat  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wstate <= w_wnext;
            if (w_aw_hs) begin
                r_bid   <= awid;
                r_widx  <= awaddr[MEM_AW+1:2];
                r_wlen  <= awlen[3:0];
                r_wbeat <= '0;
                r_err   <= 1'b0;
            end
            if (w_w_hs) begin
                r_widx  <= r_widx + MEM_AW'(1);
                r_wbeat <= r_wbeat + BEAT_W'(1);
                r_err   <= r_err | (wlast != w_wend);
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed checks of the AXI SRAM slave, zero-delay and delayed-read instances
module tb_axi_sram_slave;
    logic        aclk = 1'b0;
    logic        reset;
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, d_araddr;
    logic [7:0]  arlen, awlen;
    logic        arvalid, rready, d_arvalid, d_rready;
    logic        awvalid, wvalid, wlast, bready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        arready, rvalid, rlast, awready, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic        d_arready, d_rvalid, d_rlast, d_awready, d_wready, d_bvalid;
    logic [3:0]  d_rid, d_bid;
    logic [31:0] d_rdata;
    logic [1:0]  d_rresp, d_bresp;
    int          n_tot = 0;
    int          n_bad = 0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.MEM_AW(14), .RD_DELAY(0)) u_dut (
        .aclk(aclk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2), .arburst(2'd1), .arlock(2'd0),
        .arcache(4'd0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(2'd1), .awlock(2'd0),
        .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
        .wid(awid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axi_sram_slave #(.MEM_AW(14), .RD_DELAY(3)) u_dly (
        .aclk(aclk), .reset(reset),
        .arid(arid), .araddr(d_araddr), .arlen(arlen), .arsize(3'd2), .arburst(2'd1), .arlock(2'd0),
        .arcache(4'd0), .arprot(3'd0), .arvalid(d_arvalid), .arready(d_arready),
        .rid(d_rid), .rdata(d_rdata), .rresp(d_rresp), .rlast(d_rlast), .rvalid(d_rvalid), .rready(d_rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(2'd1), .awlock(2'd0),
        .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(d_awready),
        .wid(awid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(d_wready),
        .bid(d_bid), .bresp(d_bresp), .bvalid(d_bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                      input logic [31:0] d0, input logic [3:0] strb, input int last_at, input int bhold,
                      output logic [3:0] o_id, output logic [1:0] o_resp);
        int k;
        awaddr = addr; awid = id; awlen = {4'h0, len}; awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin @(posedge aclk); #1; k++; end
        chk("aw_timeout", k < 50, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        chk("wready_lat", wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = d0 + i; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
            k = 0;
            while (!wready && k < 50) begin @(posedge aclk); #1; k++; end
            chk("w_timeout", k < 50, 1);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_lat", bvalid, 1);
        o_id = bid; o_resp = bresp;
        for (int i = 0; i < bhold; i++) begin
            @(posedge aclk); #1;
            chk("b_hold", {bvalid, bid, bresp}, {1'b1, o_id, o_resp});
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len, input logic [31:0] e0);
        int k;
        araddr = addr; arid = id; arlen = {4'h0, len}; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin @(posedge aclk); #1; k++; end
        chk("ar_timeout", k < 50, 1);
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            k = 0;
            while (!rvalid && k < 50) begin @(posedge aclk); #1; k++; end
            chk("r_edges", k + 1, 2);
            chk("r_data", rdata, e0 + i);
            chk("r_last", rlast, i == int'(len));
            chk("r_id_resp", {rid, rresp}, {id, 2'b00});
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0]  o_id;
        logic [1:0]  o_resp;
        logic        stalled, s_last, ar_hs;
        logic [31:0] s_data;
        int          n, c;
        reset = 1'b1;
        arvalid = 0; rready = 0; d_arvalid = 0; d_rready = 0; awvalid = 0; wvalid = 0; wlast = 0; bready = 0;
        arid = 0; araddr = 0; d_araddr = 0; arlen = 0; awid = 0; awaddr = 0; awlen = 0; wdata = 0; wstrb = 0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_readies", {arready, awready, wready}, 3'b000);
        chk("rst_valids", {rvalid, bvalid, rlast}, 3'b000);
        chk("rst_payload", {rid, bid, rresp, bresp, rdata}, 44'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {arready, awready}, 2'b11);

        wr(32'h1000, 4'd1, 4'd0, 32'hDEADBEEF, 4'hF, 0, 0, o_id, o_resp);
        chk("single_b", {o_id, o_resp}, {4'd1, 2'b00});
        rd(32'h1000, 4'd0, 4'd0, 32'hDEADBEEF);

        wr(32'h2000, 4'd3, 4'd3, 32'h0, 4'hF, 3, 0, o_id, o_resp);
        chk("burst_b", {o_id, o_resp}, {4'd3, 2'b00});
        rd(32'h2000, 4'd7, 4'd3, 32'h0);

        wr(32'h4000, 4'd2, 4'd0, 32'hFFFFFFFF, 4'hF, 0, 0, o_id, o_resp);
        wr(32'h4000, 4'd2, 4'd0, 32'h00000000, 4'h5, 0, 0, o_id, o_resp);
        rd(32'h4000, 4'd2, 4'd0, 32'hFF00FF00);

        wr(32'h5000, 4'd9, 4'd3, 32'hA0, 4'hF, 1, 0, o_id, o_resp);
        chk("err_b", {o_id, o_resp}, {4'd9, 2'b10});
        rd(32'h5000, 4'd9, 4'd3, 32'hA0);

        wr(32'h3000, 4'd5, 4'd3, 32'h100, 4'hF, 3, 5, o_id, o_resp);
        chk("bp_b", {o_id, o_resp}, {4'd5, 2'b00});
        d_araddr = 32'h3000; arid = 4'd5; arlen = 8'd3; d_arvalid = 1'b1; d_rready = 1'b0;
        n = 0; c = 0; stalled = 1'b0; s_last = 1'b0; s_data = '0;
        while (n < 4 && c < 200) begin
            ar_hs = d_arvalid && d_arready;
            if (stalled) chk("bp_stable", {d_rvalid, d_rlast, d_rid, d_rdata}, {1'b1, s_last, 4'd5, s_data});
            if (d_rvalid && d_rready) begin
                chk("bp_data", d_rdata, 32'h100 + n);
                chk("bp_last", d_rlast, n == 3);
                n++;
            end
            stalled = d_rvalid && !d_rready;
            s_last = d_rlast; s_data = d_rdata;
            @(posedge aclk); #1;
            c++;
            if (ar_hs) d_arvalid = 1'b0;
            d_rready = ~d_rready;
        end
        d_rready = 1'b0;
        chk("bp_beats", n, 4);

        araddr = 32'h2000; arid = 4'd4; arlen = 8'd3; arvalid = 1'b1;
        c = 0;
        while (!arready && c < 50) begin @(posedge aclk); #1; c++; end
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        c = 0;
        while (!rvalid && c < 50) begin @(posedge aclk); #1; c++; end
        chk("rst_mid_beat0", rdata, 32'h0);
        @(posedge aclk); #1;
        reset = 1'b1;
        @(posedge aclk); #1;
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_arready", arready, 0);
        reset = 1'b0; rready = 1'b0;
        #1;
        chk("rst_rel_arready", arready, 1);
        @(posedge aclk); #1;
        rd(32'h2000, 4'd6, 4'd3, 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
